// File: rtl/spi_bus_gate.sv
// spi_bus_gate: SPI-slave gateway from an external host to the internal
// port bus. A frame is AW address bits followed by any number of DW-bit data
// words, all MSB first. Every received word is presented on RXD together with
// a one-cycle RXE pulse. The word to send back is taken from TXD at the start
// of each data word, and that load is flagged by a one-cycle TXE pulse.
//
// Ports
//   CLK           system clock, rising edge
//   nRST          asynchronous active-low reset
//   SCLK/MOSI/nCS host pins, asynchronous to CLK
//   MISO          host data out (MSB first)
//   RXD  [DW]     last complete word received
//   TXD  [DW]     word to send, supplied by the addressed port
//   ADDR [AW]     current port address
//   SEL           frame active and address valid
//   RXE           one-cycle pulse: RXD holds a new word for ADDR
//   TXE           one-cycle pulse: TXD latched into the shift register
module spi_bus_gate #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int CS_FLT_TAPS = 3,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int AUTO_INC    = 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          SCLK,
    input  logic          MOSI,
    input  logic          nCS,
    output logic          MISO,
    output logic [DW-1:0] RXD,
    input  logic [DW-1:0] TXD,
    output logic [AW-1:0] ADDR,
    output logic          SEL,
    output logic          RXE,
    output logic          TXE
);

    localparam int CW = 6;  // bit counter, covers AW <= 16 and DW <= 32

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    logic [1:0]             sclk_sync_reg, mosi_sync_reg, ncs_sync_reg;
    logic                   sclk_d_reg;
    logic [CS_FLT_TAPS-1:0] cs_flt_reg;
    logic                   cs_act_reg, armed_reg;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [AW-1:0]          addr_reg, addr_next;
    logic [DW-1:0]          rx_sh_reg, rx_sh_next;
    logic [DW-1:0]          rxd_reg, rxd_next;
    logic [DW-1:0]          tx_reg, tx_next;
    logic                   sel_reg, sel_next, sel_d_reg;
    logic                   rxe_reg, rxe_next, rxe_d_reg;
    logic                   txe_reg, txe_next;

    logic sclk_s, mosi_s, ncs_s;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge;
    logic [AW-1:0] addr_shifted;
    logic [DW-1:0] rx_shifted;

    assign sclk_s = sclk_sync_reg[1];
    assign mosi_s = mosi_sync_reg[1];
    assign ncs_s  = ncs_sync_reg[1];

    assign sclk_rise   = sclk_s & ~sclk_d_reg;
    assign sclk_fall   = ~sclk_s & sclk_d_reg;
    assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
    assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

    assign addr_shifted = (addr_reg << 1) | AW'(mosi_s);
    assign rx_shifted   = (rx_sh_reg << 1) | DW'(mosi_s);

    // Synchronisers, nCS deglitch filter and frame-active flag.
    // armed_reg only sets once the filter has seen nCS high, so after reset a
    // frame needs a fresh nCS falling edge even if nCS was held low throughout.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            ncs_sync_reg  <= '0;
            sclk_d_reg    <= 1'b0;
            cs_flt_reg    <= '0;
            cs_act_reg    <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[0], SCLK};
            mosi_sync_reg <= {mosi_sync_reg[0], MOSI};
            ncs_sync_reg  <= {ncs_sync_reg[0], nCS};
            sclk_d_reg    <= sclk_s;
            cs_flt_reg    <= {cs_flt_reg[CS_FLT_TAPS-2:0], ncs_s};
            if (&cs_flt_reg) begin
                cs_act_reg <= 1'b0;
                armed_reg  <= 1'b1;
            end else if ((cs_flt_reg == '0) && armed_reg) begin
                cs_act_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            rx_sh_reg <= '0;
            rxd_reg   <= '0;
            tx_reg    <= '0;
            sel_reg   <= 1'b0;
            sel_d_reg <= 1'b0;
            rxe_reg   <= 1'b0;
            rxe_d_reg <= 1'b0;
            txe_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            rx_sh_reg <= rx_sh_next;
            rxd_reg   <= rxd_next;
            tx_reg    <= tx_next;
            sel_reg   <= sel_next;
            sel_d_reg <= sel_reg;
            rxe_reg   <= rxe_next;
            rxe_d_reg <= rxe_reg;
            txe_reg   <= txe_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        rx_sh_next = rx_sh_reg;
        rxd_next   = rxd_reg;
        tx_next    = tx_reg;
        sel_next   = sel_reg;
        rxe_next   = 1'b0;
        txe_next   = 1'b0;

        if (!cs_act_reg) begin
            // Deselect: a partial word is dropped; ADDR and RXD keep their values.
            state_next = ST_IDLE;
            cnt_next   = '0;
            sel_next   = 1'b0;
            tx_next    = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ADDR;
                    cnt_next   = '0;
                    tx_next    = '0;
                end
                ST_ADDR: begin
                    tx_next = '0;
                    if (sample_edge) begin
                        addr_next = addr_shifted;
                        if (cnt_reg == CW'(AW - 1)) begin
                            cnt_next   = '0;
                            sel_next   = 1'b1;
                            state_next = ST_DATA;
                        end else begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (sample_edge) begin
                        rx_sh_next = rx_shifted;
                        if (cnt_reg == CW'(DW - 1)) begin
                            rxd_next = rx_shifted;
                            rxe_next = 1'b1;
                            cnt_next = '0;
                        end else begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end
                    if (rxe_reg && (AUTO_INC != 0)) begin
                        addr_next = addr_reg + AW'(1);
                    end
                    // Load the next word once ADDR is settled: right after SEL
                    // rises, or two cycles after RXE (after any increment).
                    // A load takes priority over a shift in the same cycle.
                    if ((sel_reg && !sel_d_reg) || rxe_d_reg) begin
                        tx_next  = TXD;
                        txe_next = 1'b1;
                    end else if (shift_edge && (cnt_reg != '0)) begin
                        tx_next = tx_reg << 1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign MISO = tx_reg[DW-1];
    assign RXD  = rxd_reg;
    assign ADDR = addr_reg;
    assign SEL  = sel_reg;
    assign RXE  = rxe_reg;
    assign TXE  = txe_reg;

endmodule

// File: tb/tb_spi_bus_gate.sv
// Testbench for spi_bus_gate. Seven instances share one host model:
//   0     AW=8 DW=8 mode 0 AUTO_INC=1, TXD = 0x80|ADDR
//   1..4  AW=8 DW=16 modes 0..3, TXD = 0x1234
//   5     AW=4 DW=8 AUTO_INC=1, TXD = 0xC0|ADDR
//   6     AW=4 DW=8 AUTO_INC=0, TXD = 0xC0|ADDR
// Only the instance selected by cur sees SCLK/nCS activity.
module tb_spi_bus_gate;
    localparam int TAPS = 3;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic nrst;
    logic h_sclk, h_mosi, h_ncs;
    int   cur;

    always #5 clk = ~clk;

    // instance 0
    logic       sclk0, ncs0, miso0, sel0, rxe0, txe0;
    logic [7:0] rxd0, addr0, txd0;
    assign sclk0 = (cur == 0) ? h_sclk : 1'b0;
    assign ncs0  = (cur == 0) ? h_ncs  : 1'b1;
    assign txd0  = 8'h80 | addr0;
    spi_bus_gate #(.AW(8), .DW(8), .CS_FLT_TAPS(TAPS), .CPOL(0), .CPHA(0), .AUTO_INC(1)) u_main (
        .CLK(clk), .nRST(nrst), .SCLK(sclk0), .MOSI(h_mosi), .nCS(ncs0), .MISO(miso0),
        .RXD(rxd0), .TXD(txd0), .ADDR(addr0), .SEL(sel0), .RXE(rxe0), .TXE(txe0));

    // instances 1..4
    logic [3:0]       miso_m, sel_m, rxe_m, txe_m;
    logic [3:0][15:0] rxd_m;
    logic [3:0][7:0]  addr_m;
    for (genvar gi = 0; gi < 4; gi++) begin : g_mode
        logic sclk_g, ncs_g;
        assign sclk_g = (cur == gi + 1) ? h_sclk : ((gi / 2) != 0);
        assign ncs_g  = (cur == gi + 1) ? h_ncs  : 1'b1;
        spi_bus_gate #(.AW(8), .DW(16), .CS_FLT_TAPS(TAPS), .CPOL(gi / 2), .CPHA(gi % 2), .AUTO_INC(1)) u_dut (
            .CLK(clk), .nRST(nrst), .SCLK(sclk_g), .MOSI(h_mosi), .nCS(ncs_g), .MISO(miso_m[gi]),
            .RXD(rxd_m[gi]), .TXD(16'h1234), .ADDR(addr_m[gi]), .SEL(sel_m[gi]), .RXE(rxe_m[gi]),
            .TXE(txe_m[gi]));
    end

    // instances 5 and 6
    logic [1:0]      miso_w, sel_w, rxe_w, txe_w;
    logic [1:0][7:0] rxd_w, txd_w;
    logic [1:0][3:0] addr_w;
    for (genvar gi = 0; gi < 2; gi++) begin : g_wrap
        logic sclk_g, ncs_g;
        assign sclk_g   = (cur == gi + 5) ? h_sclk : 1'b0;
        assign ncs_g    = (cur == gi + 5) ? h_ncs  : 1'b1;
        assign txd_w[gi] = 8'hC0 | {4'h0, addr_w[gi]};
        spi_bus_gate #(.AW(4), .DW(8), .CS_FLT_TAPS(TAPS), .CPOL(0), .CPHA(0), .AUTO_INC(1 - gi)) u_dut (
            .CLK(clk), .nRST(nrst), .SCLK(sclk_g), .MOSI(h_mosi), .nCS(ncs_g), .MISO(miso_w[gi]),
            .RXD(rxd_w[gi]), .TXD(txd_w[gi]), .ADDR(addr_w[gi]), .SEL(sel_w[gi]), .RXE(rxe_w[gi]),
            .TXE(txe_w[gi]));
    end

    // outputs of the selected instance, zero-extended
    logic        miso_x, sel_x, rxe_x, txe_x;
    logic [31:0] rxd_x;
    logic [15:0] addr_x;
    always_comb begin
        miso_x = 1'b0; sel_x = 1'b0; rxe_x = 1'b0; txe_x = 1'b0;
        rxd_x  = '0;   addr_x = '0;
        if (cur == 0) begin
            miso_x = miso0; sel_x = sel0; rxe_x = rxe0; txe_x = txe0;
            rxd_x = 32'(rxd0); addr_x = 16'(addr0);
        end
        for (int k = 0; k < 4; k++) begin
            if (cur == k + 1) begin
                miso_x = miso_m[k]; sel_x = sel_m[k]; rxe_x = rxe_m[k]; txe_x = txe_m[k];
                rxd_x = 32'(rxd_m[k]); addr_x = 16'(addr_m[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (cur == k + 5) begin
                miso_x = miso_w[k]; sel_x = sel_w[k]; rxe_x = rxe_w[k]; txe_x = txe_w[k];
                rxd_x = 32'(rxd_w[k]); addr_x = 16'(addr_w[k]);
            end
        end
    end

    typedef struct {
        int          dut;
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (dut %0d, t=%0t)", name, act, req, cur, $time);
        end
    endtask

    task automatic push(input int d, input logic [15:0] a, input logic [31:0] w);
        exp_t e;
        e.dut = d; e.addr = a; e.data = w;
        sb.push_back(e);
    endtask

    // scoreboard monitor and strobe timing checks
    int   cyc = 0;
    int   last_rxe = -100;
    int   sel_rise = -100;
    logic sel_prev = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (nrst && rxe_x) begin
            chk("rxe_while_sel", 64'(sel_x), 64'd1);
            chk("rxe_txe_exclusive", 64'(txe_x), 64'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rxe_unexpected dut=%0d actual addr=%0h rxd=%0h required no RXE", cur, addr_x, rxd_x);
            end else begin
                mon_e = sb.pop_front();
                $display("rxe dut=%0d addr=%0h rxd=%0h (expect %0h/%0h)", cur, addr_x, rxd_x, mon_e.addr, mon_e.data);
                chk("rxe_dut", 64'(cur), 64'(mon_e.dut));
                chk("rxe_addr", 64'(addr_x), 64'(mon_e.addr));
                chk("rxe_rxd", 64'(rxd_x), 64'(mon_e.data));
            end
            last_rxe = cyc;
        end
        if (nrst && txe_x)
            chk("txe_timing", 64'((cyc == sel_rise + 1) || (cyc == last_rxe + 2)), 64'd1);
        if (sel_x && !sel_prev) sel_rise = cyc;
        sel_prev = sel_x;
    end

    // host model
    task automatic cs_low();
        @(negedge clk);
        h_ncs = 1'b0;
        repeat (TAPS + 6) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        h_ncs = 1'b1;
        repeat (TAPS + 8) @(negedge clk);
    endtask

    task automatic send_bit(input int cpol, input int cpha, input logic b, output logic m);
        if (cpha == 0) begin
            h_mosi = b;
            repeat (HALF) @(negedge clk);
            h_sclk = (cpol == 0);
            m = miso_x;
            repeat (HALF) @(negedge clk);
            h_sclk = (cpol != 0);
        end else begin
            h_sclk = (cpol == 0);
            h_mosi = b;
            repeat (HALF) @(negedge clk);
            h_sclk = (cpol != 0);
            m = miso_x;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic frame(input int dut, input int cpol, input int cpha, input int aw,
                         input logic [63:0] bits, input int n, input int glitch_bit,
                         output logic [63:0] mo);
        logic m;
        mo = '0;
        h_sclk = (cpol != 0);
        cur = dut;
        cs_low();
        for (int i = n - 1; i >= 0; i--) begin
            if (n - 1 - i == glitch_bit) begin
                h_ncs = 1'b1;
                repeat (2) @(negedge clk);
                h_ncs = 1'b0;
                repeat (4) @(negedge clk);
            end
            chk("sel_in_frame", 64'(sel_x), 64'((n - 1 - i) >= aw));
            send_bit(cpol, cpha, bits[i], m);
            mo[i] = m;
        end
        cs_high();
        chk("sel_after_frame", 64'(sel_x), 64'd0);
        chk("miso_idle", 64'(miso_x), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] w0;
        logic [7:0] w1;
    } vec_t;
    vec_t tbl[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] mo;
        logic [7:0]  a1;
        logic        m;

        tbl[0] = '{a: 8'h12, w0: 8'hA5, w1: 8'h3C};
        tbl[1] = '{a: 8'hFF, w0: 8'h01, w1: 8'h80};
        tbl[2] = '{a: 8'h00, w0: 8'h00, w1: 8'hFF};
        tbl[3] = '{a: 8'h7E, w0: 8'h5A, w1: 8'hC3};

        nrst = 1'b0; h_ncs = 1'b1; h_sclk = 1'b0; h_mosi = 1'b0; cur = 0;
        repeat (3) @(negedge clk);
        chk("rst_miso", 64'(miso0), 64'd0);
        chk("rst_rxd", 64'(rxd0), 64'd0);
        chk("rst_addr", 64'(addr0), 64'd0);
        chk("rst_sel", 64'(sel0), 64'd0);
        chk("rst_rxe", 64'(rxe0), 64'd0);
        chk("rst_txe", 64'(txe0), 64'd0);
        nrst = 1'b1;
        repeat (12) @(negedge clk);

        // two-word frames on instance 0
        for (int v = 0; v < 4; v++) begin
            a1 = tbl[v].a + 8'd1;
            push(0, 16'(tbl[v].a), 32'(tbl[v].w0));
            push(0, 16'(a1), 32'(tbl[v].w1));
            frame(0, 0, 0, 8, {40'h0, tbl[v].a, tbl[v].w0, tbl[v].w1}, 24, -1, mo);
            chk("miso_bytes", mo, {40'h0, 8'h00, 8'h80 | tbl[v].a, 8'h80 | a1});
        end

        // all four SPI modes, 16-bit words
        for (int md = 0; md < 4; md++) begin
            push(md + 1, 16'h0040, 32'h0000BEEF);
            frame(md + 1, md / 2, md % 2, 8, {40'h0, 8'h40, 16'hBEEF}, 24, -1, mo);
            chk("mode_miso_word", 64'(mo[15:0]), 64'h1234);
            chk("mode_miso_addr_phase", 64'(mo[23:16]), 64'h0);
        end

        // 4-bit address wrap, then fixed address
        push(5, 16'hF, 32'h11);
        push(5, 16'h0, 32'h22);
        frame(5, 0, 0, 4, {44'h0, 4'hF, 8'h11, 8'h22}, 20, -1, mo);
        chk("wrap_miso", 64'(mo[15:0]), 64'hCFC0);
        push(6, 16'hF, 32'h11);
        push(6, 16'hF, 32'h22);
        frame(6, 0, 0, 4, {44'h0, 4'hF, 8'h11, 8'h22}, 20, -1, mo);
        chk("fixed_miso", 64'(mo[15:0]), 64'hCFCF);

        // 2-CLK nCS glitch while idle, then inside a data word
        cur = 0; h_sclk = 1'b0;
        @(negedge clk); h_ncs = 1'b0;
        repeat (2) @(negedge clk); h_ncs = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_glitch_sel", 64'(sel0), 64'd0);
        push(0, 16'h21, 32'h66);
        push(0, 16'h22, 32'h99);
        frame(0, 0, 0, 8, {40'h0, 8'h21, 8'h66, 8'h99}, 24, 12, mo);
        chk("glitch_miso", mo, 64'h00A1A2);

        // deselect after 5 data bits: no RXE, SEL falls after the filter delay
        cs_low();
        for (int i = 7; i >= 0; i--) send_bit(0, 0, 1'((8'h33 >> i) & 8'h1), m);
        for (int i = 0; i < 5; i++) send_bit(0, 0, 1'b1, m);
        h_ncs = 1'b1;
        repeat (TAPS + 2) @(negedge clk);
        chk("desel_sel_held", 64'(sel0), 64'd1);
        repeat (2) @(negedge clk);
        chk("desel_sel_low", 64'(sel0), 64'd0);
        chk("desel_addr_hold", 64'(addr0), 64'h33);
        chk("desel_rxd_hold", 64'(rxd0), 64'h99);
        repeat (10) @(negedge clk);

        // nRST mid-word: immediate reset, no activity until a fresh nCS fall
        cs_low();
        for (int i = 7; i >= 0; i--) send_bit(0, 0, 1'((8'h12 >> i) & 8'h1), m);
        for (int i = 0; i < 3; i++) send_bit(0, 0, 1'b1, m);
        chk("pre_rst_sel", 64'(sel0), 64'd1);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst_miso", 64'(miso0), 64'd0);
        chk("mid_rst_rxd", 64'(rxd0), 64'd0);
        chk("mid_rst_addr", 64'(addr0), 64'd0);
        chk("mid_rst_sel", 64'(sel0), 64'd0);
        chk("mid_rst_rxe", 64'(rxe0), 64'd0);
        chk("mid_rst_txe", 64'(txe0), 64'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(0, 0, 1'b1, m);
        chk("post_rst_sel", 64'(sel0), 64'd0);
        cs_high();

        push(0, 16'h12, 32'hA5);
        push(0, 16'h13, 32'h3C);
        frame(0, 0, 0, 8, {40'h0, 8'h12, 8'hA5, 8'h3C}, 24, -1, mo);
        chk("post_rst_miso", mo, 64'h009293);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_bus_gate.md
# spi_bus_gate

Parametrised SPI-slave gateway between an external host controller and the internal port bus. It generalises the fixed 8-bit gateway: configurable address width, data word width and SPI mode, plus address auto-increment for multi-word bursts, a one-cycle TX-load strobe and asynchronous reset. It sits at the FPGA pins on one side and drives the shared RXD/TXD/ADDR/SEL/RXE bus read by the IO port blocks on the other.

## Interface
- AW, 8: address field width in bits (1..16).
- DW, 8: data word width in bits (2..32).
- CS_FLT_TAPS, 3: nCS deglitch depth in CLK samples (≥2).
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- AUTO_INC, 1: 1 = ADDR increments after every data word; 0 = ADDR fixed for the frame.

- CLK  in  1  global clock; all logic on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- SCLK, MOSI, nCS  in  1 each  host pins, asynchronous to CLK.
- MISO  out  1  host data out, MSB first.
- RXD  out  DW  last complete word received.
- TXD  in  DW  word to send, supplied by the addressed port.
- ADDR  out  AW  current port address.
- SEL  out  1  high while frame active and address valid.
- RXE  out  1  one-cycle pulse: RXD holds a new word for ADDR.
- TXE  out  1  one-cycle pulse: TXD latched into the shift register in this cycle.

## Operation
- SCLK, MOSI, nCS each pass a 2-FF synchroniser. nCS then passes a CS_FLT_TAPS shift filter. cs_act sets after CS_FLT_TAPS consecutive low samples and clears after CS_FLT_TAPS consecutive high samples. Otherwise cs_act holds.
- Sample edge = SCLK leading edge if CPHA=0, else trailing edge. Leading edge is rising when CPOL=0. The other edge is the shift edge. Edges come from the synchronised SCLK and its 1-cycle delayed copy.
- FSM IDLE → ADDR → DATA.
  - Any state → IDLE when cs_act=0.
  - IDLE → ADDR on cs_act rise; bit counter cleared.
  - ADDR: each sample edge shifts MOSI into the address, MSB first. After AW bits → DATA. SEL rises in the same cycle the last address bit is stored.
  - DATA: each sample edge shifts MOSI into the rx register. On the DW-th bit, RXD takes the full word, RXE pulses, and the bit counter wraps to 0.
- Auto-increment: the cycle after RXE, if AUTO_INC=1, ADDR ← ADDR+1 mod 2^AW (wraps 2^AW−1 → 0). With AUTO_INC=0, ADDR stays constant.
- TX load: the tx register loads TXD and TXE pulses in two cases:
  - the cycle after SEL rises;
  - the second cycle after each RXE, i.e. after any increment.
- MISO = tx[DW−1].
  - On a shift edge, tx shifts left only when the bit counter ≠ 0. A load in the same cycle wins over a shift.
  - In IDLE and ADDR, tx = 0, so MISO = 0.
- Deselect mid-word: the partial word is discarded with no RXE. SEL clears one cycle after cs_act clears, and tx clears. ADDR and RXD hold their values until the next frame's address overwrites ADDR.

## Timing
- Reset values: MISO=0, RXD=0, ADDR=0, SEL=0, RXE=0, TXE=0; FSM=IDLE; filter and synchronisers cleared.
- Pin edge to internal sample-edge detect: 3 CLK.
- Sample-edge detect cycle t:
  - RXE at t+1;
  - ADDR increment at t+2;
  - TXE and MISO valid at t+3.
- Host constraint: each SCLK half-period ≥ 6 CLK. nCS setup/hold to the first/last SCLK edge ≥ CS_FLT_TAPS+3 CLK.
- RXE and TXE never assert in the same cycle. RXE is never asserted while SEL=0.
- nRST assertion mid-frame forces reset values immediately. After release, the block waits for a fresh nCS falling edge plus the filter delay.

## Test plan
- Mode 0, AW=8, DW=8, AUTO_INC=1: frame with address 0x12, MOSI words 0xA5, 0x3C; TXD = 0x80|ADDR → RXE with (ADDR,RXD) = (0x12,0xA5) then (0x13,0x3C); MISO bytes 0x92, 0x93; SEL high from the 8th bit until cs_act falls.
- All four CPOL/CPHA modes, DW=16: word 0xBEEF in, TXD=0x1234 → RXD=0xBEEF and MISO=0x1234 bit-exact each mode.
- Address wrap: AW=4, address 0xF, two words → second RXE has ADDR=0x0. AUTO_INC=0 → both RXE at ADDR=0xF.
- nCS glitch of 2 CLK (taps 3) → no FSM change. Deselect after 5 data bits → no RXE; SEL falls one cycle after cs_act falls.
- nRST pulsed mid-word → all outputs at reset values the same cycle; the next full frame decodes correctly.
- Timing check: RXE to TXE is exactly 2 CLK; sample edge to RXE is 1 CLK; TXE also occurs 1 CLK after SEL rises.
